// File: rtl/shift_reg_sequencer.sv
// Command sequencer for a 4-bit serial/parallel shift register: CLEAR, LOAD, SHIFT_IN, ROTATE.
// Optional SHIFT_REG_SEQUENCER_STEP_EN adds a step qualifier on shift cycles.
module shift_reg_sequencer #(
   parameter int NBITS = 4,
   parameter int LEN_W = 4
) (
   input  logic             clk_2,
   input  logic             reset,
`ifdef SHIFT_REG_SEQUENCER_STEP_EN
   input  logic             step,
`endif
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [NBITS-1:0] cmd_data,
   input  logic             ser_in,
   input  logic [NBITS-1:0] sr_q,
   output logic             sr_clr,
   output logic             sr_select,
   output logic [NBITS-1:0] sr_par,
   output logic             sr_serial,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] remaining
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
   typedef enum logic [1:0] {OP_CLEAR = 2'b00, OP_LOAD = 2'b01,
                             OP_SHIFT_IN = 2'b10, OP_ROTATE = 2'b11} op_t;

   state_t             state, state_nxt;
   op_t                op_q;
   logic [NBITS-1:0]   data_q;
   logic [LEN_W-1:0]   rem_q, rem_nxt;
   logic               accept;
   logic               shift_en;

   assign accept = cmd_valid && (state == S_IDLE);

`ifdef SHIFT_REG_SEQUENCER_STEP_EN
   assign shift_en = step;
`else
   assign shift_en = 1'b1;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         rem_q  <= '0;
         op_q   <= OP_CLEAR;
         data_q <= '0;
      end else begin
         state <= state_nxt;
         rem_q <= rem_nxt;
         if (accept) begin
            op_q   <= op_t'(cmd_op);
            data_q <= cmd_data;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      rem_nxt   = rem_q;
      sr_clr    = 1'b0;
      sr_select = 1'b1;
      sr_par    = sr_q;
      sr_serial = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               rem_nxt = cmd_len;
               // Zero-length shifts skip EXEC so the register is never touched.
               if (cmd_op[1] && (cmd_len == '0)) state_nxt = S_DONE;
               else                              state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_CLEAR: begin
                  sr_clr    = 1'b1;
                  state_nxt = S_DONE;
               end
               OP_LOAD: begin
                  sr_par    = data_q;
                  state_nxt = S_DONE;
               end
               OP_SHIFT_IN, OP_ROTATE: begin
                  if (shift_en) begin
                     sr_select = 1'b0;
                     sr_serial = (op_q == OP_ROTATE) ? sr_q[0] : ser_in;
                     rem_nxt   = rem_q - 1'b1;
                     if (rem_q == LEN_W'(1)) state_nxt = S_DONE;
                  end
               end
            endcase
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign remaining = rem_q;

endmodule
